// File: rtl/vector_pipe_pkg.sv
// Shared types and helpers for the vector pipeline register chain.
// Lane masking helper is width-generic up to MAX_BEAT_W / MAX_LANES.
package vector_pipe_pkg;

    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 32;
    localparam int CTRL_W_DEF = 8;

    localparam int MAX_LANES  = 64;
    localparam int MAX_BEAT_W = 1024;

    typedef logic [LANE_W_DEF-1:0] lane_t;

    // Zero every lane whose mask bit is clear; lane 0 sits in the LSBs.
    function automatic logic [MAX_BEAT_W-1:0] apply_mask(
        input logic [MAX_BEAT_W-1:0] data,
        input logic [MAX_LANES-1:0]  mask,
        input int                    lanes,
        input int                    lane_w
    );
        logic [MAX_BEAT_W-1:0] ones;
        logic [MAX_BEAT_W-1:0] res;
        logic [MAX_LANES-1:0]  m_sh;
        ones = {MAX_BEAT_W{1'b1}};
        ones = ~(ones << lane_w);
        res  = data;
        for (int k = 0; k < MAX_LANES; k++) begin
            m_sh = mask >> k;
            if (k < lanes && !m_sh[0]) begin
                res = res & ~(ones << (k * lane_w));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/vector_pipe_skid_stage.sv
// One elastic stage: main register plus skid register.
// up_ready comes straight from the skid flag flop.
module vector_pipe_skid_stage
    import vector_pipe_pkg::*;
#(
    parameter int W = 136
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_data,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [W-1:0] down_data
);

    logic         main_valid_q;
    logic         main_valid_d;
    logic         skid_valid_q;
    logic         skid_valid_d;
    logic [W-1:0] main_data_q;
    logic [W-1:0] main_data_d;
    logic [W-1:0] skid_data_q;
    logic [W-1:0] skid_data_d;
    logic         accept;
    logic         drain;

    assign up_ready   = !skid_valid_q;
    assign down_valid = main_valid_q;
    assign down_data  = main_data_q;

    always_comb begin
        accept       = up_valid && !skid_valid_q;
        drain        = main_valid_q && down_ready;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            // a full skid blocks accept, so only one source can refill main
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d = up_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = up_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = up_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: rtl/vector_pipe_chain.sv
// Elastic vector pipeline chain: DEPTH skid stages, lane mask, occupancy.
// Define VECTOR_PIPE_STALL_CNT_EN to add the saturating stall_cnt output.
module vector_pipe_chain
    import vector_pipe_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CTRL_W-1:0]            in_ctrl,
    input  logic [LANES*LANE_W-1:0]      in_data,
    input  logic [LANES-1:0]             in_mask,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CTRL_W-1:0]            out_ctrl,
    output logic [LANES*LANE_W-1:0]      out_data,
    output logic [$clog2(2*DEPTH+1)-1:0] occupancy
`ifdef VECTOR_PIPE_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam int DATA_W = LANES * LANE_W;
    localparam int BEAT_W = CTRL_W + DATA_W;
    localparam int OCC_W  = $clog2(2*DEPTH+1);

    logic [DATA_W-1:0]            masked_data;
    logic [DEPTH:0]               v;
    logic [DEPTH:0]               r;
    logic [DEPTH:0][BEAT_W-1:0]   d;
    logic                         in_hs;
    logic                         out_hs;
    logic [OCC_W-1:0]             occ_q;
    logic [OCC_W-1:0]             occ_d;

    always_comb begin
        masked_data = DATA_W'(apply_mask(MAX_BEAT_W'(in_data),
                                         MAX_LANES'(in_mask),
                                         LANES, LANE_W));
    end

    assign v[0]     = in_valid;
    assign d[0]     = {in_ctrl, masked_data};
    assign in_ready = r[0];
    assign r[DEPTH] = out_ready;

    assign out_valid             = v[DEPTH];
    assign {out_ctrl, out_data}  = d[DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        vector_pipe_skid_stage #(
            .W (BEAT_W)
        ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .flush      (flush),
            .up_valid   (v[i]),
            .up_ready   (r[i]),
            .up_data    (d[i]),
            .down_valid (v[i+1]),
            .down_ready (r[i+1]),
            .down_data  (d[i+1])
        );
    end

    assign in_hs     = in_valid && r[0];
    assign out_hs    = v[DEPTH] && out_ready;
    assign occupancy = occ_q;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_hs && !out_hs) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_hs && out_hs) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

`ifdef VECTOR_PIPE_STALL_CNT_EN
    logic [31:0] stall_q;
    logic [31:0] stall_d;

    assign stall_cnt = stall_q;

    // flush does not clear this; it is a lifetime stall statistic
    always_comb begin
        stall_d = stall_q;
        if (v[DEPTH] && !out_ready && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_vector_pipe_chain.sv
// Directed bench for vector_pipe_chain (default parameters).
// Define VECTOR_PIPE_STALL_CNT_EN to also exercise stall_cnt.
module tb_vector_pipe_chain;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_ctrl;
    logic [127:0] in_data;
    logic [3:0]   in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_ctrl;
    logic [127:0] out_data;
    logic [2:0]   occupancy;
`ifdef VECTOR_PIPE_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    vector_pipe_chain dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef VECTOR_PIPE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   ctrl;
        logic [127:0] data;
        logic [3:0]   mask;
        logic [7:0]   exp_ctrl;
        logic [127:0] exp_data;
    } vec_t;

    vec_t vecs [5];
    int   checks;
    int   errors;
    int   tx;
    int   rx;
    logic hs;
    logic seen;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lane0(input int val);
        logic [31:0] t;
        t = val[31:0];
        return {96'd0, t};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{8'h3C, {4{32'h1111_2222}}, 4'hF,
                    8'h3C, {4{32'h1111_2222}}};
        vecs[1] = '{8'hA5, {4{32'hFFFF_FFFF}}, 4'b0101,
                    8'hA5, {32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF}};
        vecs[2] = '{8'h00,
                    {32'hDEAD_BEEF, 32'hCAFE_BABE, 32'h1234_5678, 32'h9ABC_DEF0},
                    4'b1000,
                    8'h00, {32'hDEAD_BEEF, 96'h0}};
        vecs[3] = '{8'hFF, {4{32'h5555_AAAA}}, 4'b0000,
                    8'hFF, 128'h0};
        vecs[4] = '{8'h5A,
                    {32'hAAAA_0003, 32'hBBBB_0002, 32'hCCCC_0001, 32'hDDDD_0000},
                    4'b0110,
                    8'h5A, {32'h0, 32'hBBBB_0002, 32'hCCCC_0001, 32'h0}};

        // reset with in_valid asserted
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 8'h77;
        in_data   = {4{32'h7777_7777}};
        in_mask   = 4'hF;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_occ", 128'(occupancy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();

        // table: single beats, 2-cycle latency, masking
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_ctrl  = vecs[i].ctrl;
            in_data  = vecs[i].data;
            in_mask  = vecs[i].mask;
            chk("vec_in_ready", 128'(in_ready), 128'(1));
            tick();
            in_valid = 1'b0;
            chk("vec_lat1_valid", 128'(out_valid), 128'(0));
            tick();
            chk("vec_lat2_valid", 128'(out_valid), 128'(1));
            chk("vec_data", out_data, vecs[i].exp_data);
            chk("vec_ctrl", 128'(out_ctrl), 128'(vecs[i].exp_ctrl));
            chk("vec_occ", 128'(occupancy), 128'(1));
            tick();
            chk("vec_drained", 128'(out_valid), 128'(0));
            chk("vec_occ0", 128'(occupancy), 128'(0));
        end

        // back-to-back stream of 10 beats
        in_mask = 4'hF;
        rx      = 0;
        for (int j = 1; j <= 13; j++) begin
            in_valid = (j <= 10);
            in_data  = lane0(j - 1);
            in_ctrl  = 8'(j - 1);
            tick();
            chk("stream_valid", 128'(out_valid), 128'(j >= 2 && j <= 11));
            if (out_valid) begin
                chk("stream_data", out_data, lane0(rx));
                chk("stream_ctrl", 128'(out_ctrl), 128'(8'(rx)));
                rx++;
            end
            if (j >= 2 && j <= 10) begin
                chk("stream_occ", 128'(occupancy), 128'(2));
            end
        end
        in_valid = 1'b0;
        chk("stream_count", 128'(rx), 128'(10));

        // backpressure: fill to 4, then drain with the remaining 2
        in_ctrl   = 8'h00;
        out_ready = 1'b0;
        tx        = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = lane0(100 + tx);
            hs       = in_ready;
            tick();
            if (hs) tx++;
        end
        chk("bp_accepted", 128'(tx), 128'(4));
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        chk("bp_occ", 128'(occupancy), 128'(4));
        chk("bp_head", out_data, lane0(100));
        repeat (2) tick();
        chk("bp_hold_data", out_data, lane0(100));
        chk("bp_hold_valid", 128'(out_valid), 128'(1));
        chk("bp_hold_occ", 128'(occupancy), 128'(4));
        rx = 0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            in_valid  = (tx < 6);
            in_data   = lane0(100 + tx);
            out_ready = 1'b1;
            if (out_valid) begin
                chk("bp_drain_data", out_data, lane0(100 + rx));
                rx++;
            end
            hs = in_valid && in_ready;
            tick();
            if (hs) tx++;
        end
        in_valid = 1'b0;
        chk("bp_rx", 128'(rx), 128'(6));
        chk("bp_tx", 128'(tx), 128'(6));
        chk("bp_occ_end", 128'(occupancy), 128'(0));

        // flush with 3 beats held and in_valid in the flush cycle
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = lane0(200 + k);
            chk("fl_in_ready", 128'(in_ready), 128'(1));
            tick();
        end
        chk("fl_occ3", 128'(occupancy), 128'(3));
        in_data = lane0(999);
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", 128'(out_valid), 128'(0));
        chk("fl_occ", 128'(occupancy), 128'(0));
        chk("fl_in_ready2", 128'(in_ready), 128'(1));
        out_ready = 1'b1;
        seen      = 1'b0;
        repeat (4) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("fl_no_ghost", 128'(seen), 128'(0));

        in_valid = 1'b1;
        in_data  = lane0(300);
        tick();
        in_valid = 1'b0;
        tick();
        chk("post_fl_valid", 128'(out_valid), 128'(1));
        chk("post_fl_data", out_data, lane0(300));
        tick();

        // asynchronous reset in the middle of a cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = lane0(400);
        tick();
        in_data = lane0(401);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_pre_occ", 128'(occupancy), 128'(2));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_occ", 128'(occupancy), 128'(0));
        chk("mid_rst_data", out_data, 128'h0);
        tick();
        rst = 1'b1;
        tick();

`ifdef VECTOR_PIPE_STALL_CNT_EN
        rst = 1'b0;
        tick();
        chk("st_rst", 128'(stall_cnt), 128'(0));
        rst = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = lane0(7);
        tick();
        in_valid = 1'b0;
        tick();
        chk("st_valid", 128'(out_valid), 128'(1));
        chk("st_zero", 128'(stall_cnt), 128'(0));
        repeat (7) tick();
        chk("st_seven", 128'(stall_cnt), 128'(7));
        out_ready = 1'b1;
        flush     = 1'b1;
        tick();
        flush = 1'b0;
        chk("st_after_flush", 128'(stall_cnt), 128'(7));
        chk("st_fl_valid", 128'(out_valid), 128'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
